// File: rtl/decode_stage.sv
// decode_stage: ID stage with IF/ID and ID/EX registers, register file, hazard stall and redirect squash
module decode_stage #(
  parameter int WIDTH = 32,
  parameter int NREG = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Opcode,
  input  logic [4:0]       Reg1,
  input  logic [4:0]       Reg2,
  input  logic [15:0]      Immediate,
  input  logic [27:0]      jumped,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             Jump,
  output logic             Branch,
  output logic             Zero,
  output logic             stop,
  output logic [WIDTH-1:0] signext,
  output logic [WIDTH-1:0] ex_rs_val,
  output logic [WIDTH-1:0] ex_rt_val,
  output logic [WIDTH-1:0] ex_imm,
  output logic [4:0]       ex_dest,
  output logic [5:0]       ex_funct,
  output logic [4:0]       ex_ctrl,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
);
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  logic [5:0]       op_q, op_d;
  logic [4:0]       rs_q, rs_d, rt_q, rt_d;
  logic [15:0]      imm_q, imm_d;
  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] rf_d [NREG];
  logic [WIDTH-1:0] ex_rs_val_q, ex_rs_val_d, ex_rt_val_q, ex_rt_val_d, ex_imm_q, ex_imm_d;
  logic [4:0]       ex_dest_q, ex_dest_d, ex_ctrl_q, ex_ctrl_d;
  logic [5:0]       ex_funct_q, ex_funct_d;
  logic [4:0]       exm_dest_q, exm_dest_d;
  logic             exm_rw_q, exm_rw_d;
  logic [15:0]      stall_q, stall_d, flush_q, flush_d;
  logic             is_r, is_lw, is_sw, is_addi, is_beq, is_j;
  logic             reads_rs, reads_rt, rw, load_use, ex_hit, exm_hit, br_dep, redirect;
  logic [4:0]       dest, ctrl;
  logic [WIDTH-1:0] rs_val, rt_val;
  logic             unused_jumped;
  assign unused_jumped = ^jumped;
  assign is_r     = op_q == OP_R;
  assign is_lw    = op_q == OP_LW;
  assign is_sw    = op_q == OP_SW;
  assign is_addi  = op_q == OP_ADDI;
  assign is_beq   = op_q == OP_BEQ;
  assign is_j     = op_q == OP_J;
  assign reads_rs = is_r | is_lw | is_sw | is_addi | is_beq;
  assign reads_rt = is_r | is_sw | is_beq;
  assign dest     = is_r ? imm_q[15:11] : (is_lw | is_addi) ? rt_q : 5'd0;
  assign rw       = (is_r | is_lw | is_addi) & (dest != 5'd0);
  assign ctrl     = {rw, is_lw, is_sw, is_lw | is_sw | is_addi, is_r};
  assign rs_val   = rs_q == 5'd0 ? '0 : (wb_we && wb_addr == rs_q) ? wb_data : rf_q[rs_q];
  assign rt_val   = rt_q == 5'd0 ? '0 : (wb_we && wb_addr == rt_q) ? wb_data : rf_q[rt_q];
  assign signext  = {{(WIDTH-16){imm_q[15]}}, imm_q};
  assign Zero     = rs_val == rt_val;
  assign load_use = ex_ctrl_q[3] && ex_dest_q != 5'd0 &&
                    ((reads_rs && ex_dest_q == rs_q) || (reads_rt && ex_dest_q == rt_q));
  assign ex_hit   = ex_ctrl_q[4] && ex_dest_q != 5'd0 && (ex_dest_q == rs_q || ex_dest_q == rt_q);
  assign exm_hit  = exm_rw_q && exm_dest_q != 5'd0 && (exm_dest_q == rs_q || exm_dest_q == rt_q);
  assign br_dep   = is_beq && (ex_hit || exm_hit);
  assign stop     = load_use | br_dep;
  assign Jump     = is_j & ~stop;
  assign Branch   = is_beq & ~stop;
  assign redirect = Jump | (Branch & Zero);
  always_comb begin
    rf_d = rf_q;
    if (wb_we && wb_addr != 5'd0) rf_d[wb_addr] = wb_data;
  end
  always_comb begin
    op_d        = stop ? op_q  : redirect ? 6'd0  : Opcode;
    rs_d        = stop ? rs_q  : redirect ? 5'd0  : Reg1;
    rt_d        = stop ? rt_q  : redirect ? 5'd0  : Reg2;
    imm_d       = stop ? imm_q : redirect ? 16'd0 : Immediate;
    ex_rs_val_d = stop ? '0 : rs_val;
    ex_rt_val_d = stop ? '0 : rt_val;
    ex_imm_d    = stop ? '0 : signext;
    ex_dest_d   = stop ? 5'd0 : dest;
    ex_funct_d  = stop ? 6'd0 : imm_q[5:0];
    ex_ctrl_d   = stop ? 5'd0 : ctrl;
    exm_dest_d  = ex_dest_q;
    exm_rw_d    = ex_ctrl_q[4];
    stall_d     = stall_q + 16'(stop && stall_q != 16'hFFFF);
    flush_d     = flush_q + 16'(redirect && flush_q != 16'hFFFF);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      imm_q       <= '0;
      rf_q        <= '{default: '0};
      ex_rs_val_q <= '0;
      ex_rt_val_q <= '0;
      ex_imm_q    <= '0;
      ex_dest_q   <= '0;
      ex_funct_q  <= '0;
      ex_ctrl_q   <= '0;
      exm_dest_q  <= '0;
      exm_rw_q    <= 1'b0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      op_q        <= op_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      imm_q       <= imm_d;
      rf_q        <= rf_d;
      ex_rs_val_q <= ex_rs_val_d;
      ex_rt_val_q <= ex_rt_val_d;
      ex_imm_q    <= ex_imm_d;
      ex_dest_q   <= ex_dest_d;
      ex_funct_q  <= ex_funct_d;
      ex_ctrl_q   <= ex_ctrl_d;
      exm_dest_q  <= exm_dest_d;
      exm_rw_q    <= exm_rw_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
    end
  end
  assign ex_rs_val = ex_rs_val_q;
  assign ex_rt_val = ex_rt_val_q;
  assign ex_imm    = ex_imm_q;
  assign ex_dest   = ex_dest_q;
  assign ex_funct  = ex_funct_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage that consumes the fetch stage's field outputs (Opcode, Reg1, Reg2, Immediate, jumped).
- Drives the fetch-side controls back: Jump, Branch, Zero, stop, signext.
- Holds the IF/ID pipeline register, a register file with a write-back port, hazard/stall logic, redirect squash, and the ID/EX pipeline register feeding execute.

Parameters:
- WIDTH, 32, datapath and register width.
- NREG, 32, number of architectural registers; address width is fixed at 5.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- Opcode  input  6  fetched opcode.
- Reg1  input  5  fetched rs.
- Reg2  input  5  fetched rt.
- Immediate  input  16  fetched imm; for R-type, [15:11]=rd and [5:0]=funct.
- jumped  input  28  fetched jump target, already shifted left by 2.
- wb_we  input  1  write-back enable.
- wb_addr  input  5  write-back register.
- wb_data  input  WIDTH  write-back data.
- Jump  output  1  take jump (comb).
- Branch  output  1  beq resolved in ID (comb).
- Zero  output  1  rs_val==rt_val (comb).
- stop  output  1  freeze fetch PC and IF/ID (comb).
- signext  output  WIDTH  sign-extended IF/ID immediate (comb).
- ex_rs_val  output  WIDTH  ID/EX rs data.
- ex_rt_val  output  WIDTH  ID/EX rt data.
- ex_imm  output  WIDTH  ID/EX sign-extended immediate.
- ex_dest  output  5  ID/EX destination register.
- ex_funct  output  6  ID/EX funct.
- ex_ctrl  output  5  {reg_write, mem_read, mem_write, alu_src, is_rtype}.
- stall_cnt  output  16  saturating count of stall cycles.
- flush_cnt  output  16  saturating count of squashed instructions.

Behaviour:
- Decode of IF/ID opcode:
  - 000000 R-type: dest=rd, reg_write=1, is_rtype=1, reads rs+rt.
  - 100011 lw: dest=rt, reg_write, mem_read, alu_src; reads rs.
  - 101011 sw: mem_write, alu_src; reads rs+rt.
  - 001000 addi: dest=rt, reg_write, alu_src; reads rs.
  - 000100 beq: reads rs+rt.
  - 000010 j: reads none.
  - Any other opcode: all ctrl 0 (NOP).
- NOP encoding: all-zero IF/ID (opcode 0, rd 0). reg_write to r0 is suppressed everywhere.
- Register file:
  - NREG x WIDTH; r0 reads 0 and ignores writes.
  - Write on edge when wb_we=1.
  - Same-cycle read of wb_addr (nonzero, wb_we=1) returns wb_data (write-through bypass).
- signext = {{16{imm[15]}}, imm}.
- Zero = (rs_val == rt_val) after bypass.
- Hazard tracking: two internal shadow stages (ID/EX, EX/MEM), each holding {dest, reg_write, mem_read}. They advance every cycle; a bubble enters as zeros.
- stop=1 when any of the following holds:
  - (a) Load-use: ID/EX mem_read=1, dest≠0, dest equals a register the IF/ID instruction reads.
  - (b) Branch dependence: IF/ID is beq, and ID/EX or EX/MEM has reg_write=1 with dest≠0 equal to rs or rt.
- While stop=1:
  - IF/ID holds its value.
  - ID/EX and the shadow ID/EX load a bubble.
  - Branch=0, Jump=0.
  - stall_cnt increments, saturating at 0xFFFF.
- Jump = (IF/ID opcode==j) & ~stop.
- Branch = (IF/ID opcode==beq) & ~stop.
- Redirect = Jump | (Branch & Zero). On a redirect edge:
  - IF/ID loads NOP; the fetched fields presented that cycle are squashed.
  - flush_cnt increments, saturating.
  - The beq/j itself passes to ID/EX as a ctrl-0 op.
- Normal cycle: IF/ID captures inputs; ID/EX captures decoded values. Latency from fetch inputs to ex_* outputs is 2 edges.
- Priority: rst > stop > redirect > normal. stop and redirect cannot coexist, because stop gates Branch/Jump.
- Reset, applied on the edge and valid at any time including mid-stall:
  - IF/ID, ID/EX and shadows become NOP.
  - All registers = 0.
  - All ex_* = 0, stall_cnt=flush_cnt=0.
  - Combinational outputs therefore read Jump=Branch=Zero... Zero=1 (0==0), stop=0, signext=0.
  - Stall/flush state is discarded.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> all ex_*=0, counters 0, stop=0, Jump=0, Branch=0, Zero=1.
- Decode/regfile: write r8=0x00000005 via wb, then feed addi r9,r8,-3 (Imm=0xFFFD) -> two edges later ex_rs_val=5, ex_imm=0xFFFFFFFD, ex_dest=9, ex_ctrl=10010. Writing r0=0xDEAD -> r0 reads 0.
- Load-use: lw r2,0(r1) followed by add r3,r2,r4 -> exactly one cycle stop=1, bubble in ID/EX, add reaches EX the cycle after, stall_cnt=1. Same sequence with add using r5 -> no stall.
- Branch taken: r1=r2=7, feed beq r1,r2 with no in-flight writers -> Branch=1, Zero=1 same cycle, next IF/ID is NOP, flush_cnt=1. With r2=8 -> Zero=0, no flush.
- Branch dependence: addi r1,r0,7 immediately followed by beq r1,r2 -> stop=1 for 2 cycles, Branch=0 during stall, then Branch=1. With wb bypass delivering r1 on the third cycle -> Zero=1.
- Jump + reset mid-stall: j with jumped=0x0000100 -> Jump=1, following fetch squashed. Separately, assert rst during load-use stall -> stop=0 next cycle, stall_cnt=0.
